// File: rtl/conv_layer_scheduler.sv
// Sequences one binary conv layer: per output channel, fetch the kernel, run the shared
// 3x3 core, and write the resulting 1-bit feature map to the fmap buffer at address = channel.
module conv_layer_scheduler #(
    parameter int unsigned IC           = 8,
    parameter int unsigned OC           = 16,
    parameter int unsigned IMG_IN_SIZE  = 30,
    parameter int unsigned IMG_OUT_SIZE = IMG_IN_SIZE - 2,
    parameter int unsigned TIMEOUT      = IMG_OUT_SIZE**2 * IC * 10 + 16,
    localparam int unsigned AW          = (OC > 1) ? $clog2(OC) : 1,
    localparam int unsigned WW          = IC * 9,
    localparam int unsigned MW          = IMG_OUT_SIZE**2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic          wt_rd_en,
    output logic [AW-1:0] wt_addr,
    input  logic [WW-1:0] wt_data,
    output logic          core_en,
    output logic [WW-1:0] core_weights,
    input  logic          core_out_valid,
    input  logic [MW-1:0] core_img_out,
    output logic          fmap_we,
    output logic [AW-1:0] fmap_addr,
    output logic [MW-1:0] fmap_data
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] LastOc      = AW'(OC - 1);
    localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StRun,
        StWrite,
        StDone
    } state_e;

    state_e        state;
    logic [AW-1:0] oc;
    logic [TW-1:0] timer;
    logic          fmap_we_q;
    logic          done_q;

    assign busy = (state != StIdle);

    // An abort arriving during WRITE/DONE must cancel the strobe already on the wire.
    assign fmap_we = fmap_we_q & ~abort;
    assign done    = done_q & ~abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            oc           <= '0;
            timer        <= '0;
            done_q       <= 1'b0;
            error        <= 1'b0;
            wt_rd_en     <= 1'b0;
            wt_addr      <= '0;
            core_en      <= 1'b0;
            core_weights <= '0;
            fmap_we_q    <= 1'b0;
            fmap_addr    <= '0;
            fmap_data    <= '0;
        end else begin
            wt_rd_en  <= 1'b0;
            fmap_we_q <= 1'b0;
            done_q    <= 1'b0;
            if (abort) begin
                state   <= StIdle;
                core_en <= 1'b0;
            end else begin
                case (state)
                    StIdle: begin
                        if (start) begin
                            error    <= 1'b0;
                            oc       <= '0;
                            wt_addr  <= '0;
                            wt_rd_en <= 1'b1;
                            state    <= StFetch;
                        end
                    end
                    StFetch: state <= StLatch;
                    StLatch: begin
                        core_weights <= wt_data;
                        timer        <= '0;
                        core_en      <= 1'b1;
                        state        <= StRun;
                    end
                    StRun: begin
                        // A result landing on the final allowed cycle still counts.
                        if (core_out_valid) begin
                            fmap_data <= core_img_out;
                            fmap_addr <= oc;
                            fmap_we_q <= 1'b1;
                            core_en   <= 1'b0;
                            state     <= StWrite;
                        end else if (timer == TimeoutLast) begin
                            error   <= 1'b1;
                            core_en <= 1'b0;
                            state   <= StIdle;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    StWrite: begin
                        if (oc == LastOc) begin
                            done_q <= 1'b1;
                            state  <= StDone;
                        end else begin
                            oc       <= oc + 1'b1;
                            wt_addr  <= oc + 1'b1;
                            wt_rd_en <= 1'b1;
                            state    <= StFetch;
                        end
                    end
                    StDone:  state <= StIdle;
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Bench for conv_layer_scheduler: behavioural weight ROM, conv core and fmap monitor,
// with per-layer expectations computed from the channel timing and a direct 3x3 conv.
module tb_conv_layer_scheduler;

    localparam int IC      = 1;
    localparam int OC      = 2;
    localparam int IMGI    = 4;
    localparam int IMGO    = IMGI - 2;
    localparam int TCORE   = IMGO * IMGO * IC * 10;
    localparam int TIMEOUT = TCORE + 16;
    localparam int WW      = IC * 9;
    localparam int MW      = IMGO * IMGO;
    localparam int IW      = IMGI * IMGI;
    localparam int AW      = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          busy, done, error, wt_rd_en, core_en, fmap_we;
    logic [AW-1:0] wt_addr, fmap_addr;
    logic [WW-1:0] wt_data = '0;
    logic [WW-1:0] core_weights;
    logic          core_out_valid;
    logic [MW-1:0] core_img_out, fmap_data;

    int n_run = 0;
    int n_fail = 0;

    conv_layer_scheduler #(
        .IC          (IC),
        .OC          (OC),
        .IMG_IN_SIZE (IMGI)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .wt_rd_en       (wt_rd_en),
        .wt_addr        (wt_addr),
        .wt_data        (wt_data),
        .core_en        (core_en),
        .core_weights   (core_weights),
        .core_out_valid (core_out_valid),
        .core_img_out   (core_img_out),
        .fmap_we        (fmap_we),
        .fmap_addr      (fmap_addr),
        .fmap_data      (fmap_data)
    );

    always #5 clk = ~clk;

    // Binary 3x3 conv: output bit set when a majority of the 9 taps match (XNOR-popcount).
    function automatic logic [MW-1:0] conv3(input logic [WW-1:0] w, input logic [IW-1:0] x);
        logic [MW-1:0] r;
        int m;
        r = '0;
        for (int oy = 0; oy < IMGO; oy++) begin
            for (int ox = 0; ox < IMGO; ox++) begin
                m = 0;
                for (int ky = 0; ky < 3; ky++)
                    for (int kx = 0; kx < 3; kx++)
                        if (w[ky*3+kx] == x[(oy+ky)*IMGI+ox+kx]) m++;
                r[oy*IMGO+ox] = (m >= 5);
            end
        end
        return r;
    endfunction

    // Weight ROM: data one cycle after the read strobe.
    logic [WW-1:0] rom [OC];
    always @(posedge clk) if (wt_rd_en) wt_data <= rom[wt_addr];

    // Core: result after core_lat cycles of continuous enable; clears whenever disabled.
    logic [IW-1:0] img_in = '1;
    int core_lat = TCORE;
    bit stall = 1'b0;
    bit spurious = 1'b0;
    int core_cnt = 0;
    always @(posedge clk) core_cnt <= core_en ? core_cnt + 1 : 0;
    assign core_out_valid = spurious || (core_en && !stall && core_cnt == core_lat - 1);
    assign core_img_out   = conv3(core_weights, img_in);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            wr_addr_q[$], wr_cyc_q[$], done_cyc_q[$], rd_addr_q[$], err_cyc_q[$];
    logic [MW-1:0] wr_data_q[$];
    int            gap_viol = 0, stab_viol = 0, low_run = 0;
    bit            seen_hi = 1'b0, prev_en = 1'b0, prev_err = 1'b0;
    logic [WW-1:0] prev_w = '0;

    always @(negedge clk) begin
        if (fmap_we) begin
            wr_addr_q.push_back(int'(fmap_addr));
            wr_data_q.push_back(fmap_data);
            wr_cyc_q.push_back(cyc);
        end
        if (done) done_cyc_q.push_back(cyc);
        if (wt_rd_en) rd_addr_q.push_back(int'(wt_addr));
        if (error && !prev_err) err_cyc_q.push_back(cyc);
        if (core_en && !prev_en && seen_hi && low_run < 2) gap_viol++;
        if (core_en && prev_en && core_weights !== prev_w) stab_viol++;
        if (core_en) seen_hi = 1'b1;
        low_run  = core_en ? 0 : low_run + 1;
        prev_en  = core_en;
        prev_w   = core_weights;
        prev_err = error;
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(output int s);
        @(posedge clk);
        #1 start = 1'b1;
        s = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_run++;
        if ({busy, done, error, wt_rd_en, core_en, fmap_we} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {busy, done, error, wt_rd_en, core_en, fmap_we});
        end
        n_run++;
        if ({wt_addr, fmap_addr, core_weights, fmap_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h/%h/%h expected all 0",
                     wt_addr, fmap_addr, core_weights, fmap_data);
        end
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_run++;
        if (busy !== 1'b0 || rd_addr_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b reads=%0d expected 0/0", busy, rd_addr_q.size());
        end
    endtask

    // Start counted as cycle 1: channel i writes in cycle 1+(i+1)*(3+TCORE), i.e. 44 for i=0.
    task automatic test_full_layer(input bit fixed, input bit poke);
        int s, bw, bd, br, bg, bs;
        logic [MW-1:0] exp_d;
        if (fixed) begin
            rom[0] = 9'h1FF;
            rom[1] = 9'h000;
            img_in = '1;
        end else begin
            for (int i = 0; i < OC; i++) rom[i] = WW'($urandom);
            img_in = IW'($urandom);
        end
        core_lat = TCORE;
        bw = wr_addr_q.size(); bd = done_cyc_q.size(); br = rd_addr_q.size();
        bg = gap_viol; bs = stab_viol;
        pulse_start(s);
        if (poke) begin
            wait_until(s + 50);
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        wait_until(s + OC * (3 + TCORE) + 8);

        n_run++;
        if (wr_addr_q.size() - bw != OC) begin
            n_fail++;
            $display("FAIL layer_writes: got %0d expected %0d", wr_addr_q.size() - bw, OC);
        end
        for (int i = 0; i < OC; i++) begin
            if (bw + i < wr_addr_q.size()) begin
                exp_d = conv3(rom[i], img_in);
                n_run++;
                if (wr_addr_q[bw+i] != i) begin
                    n_fail++;
                    $display("FAIL layer_addr[%0d]: got %0d expected %0d", i, wr_addr_q[bw+i], i);
                end
                n_run++;
                if (wr_data_q[bw+i] !== exp_d) begin
                    n_fail++;
                    $display("FAIL layer_data[%0d]: got %h expected %h", i, wr_data_q[bw+i], exp_d);
                end
                n_run++;
                if (wr_cyc_q[bw+i] - s != (i + 1) * (3 + TCORE)) begin
                    n_fail++;
                    $display("FAIL layer_write_cycle[%0d]: got %0d expected %0d", i,
                             wr_cyc_q[bw+i] - s, (i + 1) * (3 + TCORE));
                end
            end
        end
        if (fixed && wr_data_q.size() >= bw + 2) begin
            n_run++;
            if (wr_data_q[bw] !== 4'hF || wr_data_q[bw+1] !== 4'h0) begin
                n_fail++;
                $display("FAIL fixed_data: got %h,%h expected f,0", wr_data_q[bw], wr_data_q[bw+1]);
            end
        end
        n_run++;
        if (done_cyc_q.size() - bd != 1) begin
            n_fail++;
            $display("FAIL layer_done_count: got %0d expected 1", done_cyc_q.size() - bd);
        end else begin
            n_run++;
            if (done_cyc_q[bd] - s != OC * (3 + TCORE) + 1) begin
                n_fail++;
                $display("FAIL layer_done_cycle: got %0d expected %0d", done_cyc_q[bd] - s,
                         OC * (3 + TCORE) + 1);
            end
        end
        n_run++;
        if (rd_addr_q.size() - br != OC) begin
            n_fail++;
            $display("FAIL layer_reads: got %0d expected %0d", rd_addr_q.size() - br, OC);
        end else begin
            for (int i = 0; i < OC; i++) begin
                n_run++;
                if (rd_addr_q[br+i] != i) begin
                    n_fail++;
                    $display("FAIL layer_wt_addr[%0d]: got %0d expected %0d", i, rd_addr_q[br+i], i);
                end
            end
        end
        n_run++;
        if (busy !== 1'b0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL layer_end_state: got busy=%b error=%b expected 0/0", busy, error);
        end
        n_run++;
        if (gap_viol != bg || stab_viol != bs) begin
            n_fail++;
            $display("FAIL layer_core_en: got gap=%0d stab=%0d expected 0/0",
                     gap_viol - bg, stab_viol - bs);
        end
    endtask

    task automatic test_abort();
        int s, bw, bd, br;
        for (int i = 0; i < OC; i++) rom[i] = WW'($urandom);
        // Abort during channel-1 RUN.
        bw = wr_addr_q.size(); bd = done_cyc_q.size();
        pulse_start(s);
        wait_until(s + (3 + TCORE) + 10);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        n_run++;
        if ({busy, core_en, wt_rd_en, fmap_we} !== 4'b0) begin
            n_fail++;
            $display("FAIL abort_run_outputs: got %b expected 0000", {busy, core_en, wt_rd_en, fmap_we});
        end
        repeat (3 + TCORE + 10) @(posedge clk);
        #1;
        n_run++;
        if (wr_addr_q.size() - bw != 1 || done_cyc_q.size() != bd || error !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_run_effects: got writes=%0d dones=%0d error=%b expected 1/0/0",
                     wr_addr_q.size() - bw, done_cyc_q.size() - bd, error);
        end
        // Abort during the first WRITE cycle suppresses that write.
        bw = wr_addr_q.size();
        pulse_start(s);
        wait_until(s + 3 + TCORE);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_run++;
        if (wr_addr_q.size() != bw || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_write: got writes=%0d busy=%b expected 0/0",
                     wr_addr_q.size() - bw, busy);
        end
        // Start and abort together in IDLE: abort wins.
        br = rd_addr_q.size();
        @(posedge clk);
        #1 begin start = 1'b1; abort = 1'b1; end
        @(posedge clk);
        #1 begin start = 1'b0; abort = 1'b0; end
        repeat (3) @(posedge clk);
        #1;
        n_run++;
        if (busy !== 1'b0 || rd_addr_q.size() != br) begin
            n_fail++;
            $display("FAIL abort_with_start: got busy=%b reads=%0d expected 0/0",
                     busy, rd_addr_q.size() - br);
        end
        // Fresh start reruns from channel 0.
        bw = wr_addr_q.size();
        pulse_start(s);
        wait_until(s + OC * (3 + TCORE) + 8);
        n_run++;
        if (wr_addr_q.size() - bw != OC || wr_addr_q[bw] != 0 || wr_addr_q[bw+1] != 1) begin
            n_fail++;
            $display("FAIL abort_rerun: got %0d writes expected %0d at addrs 0,1",
                     wr_addr_q.size() - bw, OC);
        end
    endtask

    task automatic test_timeout();
        int s, bw, bd, be;
        stall = 1'b1;
        bw = wr_addr_q.size(); bd = done_cyc_q.size(); be = err_cyc_q.size();
        pulse_start(s);
        wait_until(s + 2 + TIMEOUT + 10);
        n_run++;
        if (err_cyc_q.size() - be != 1) begin
            n_fail++;
            $display("FAIL timeout_error: got %0d rises expected 1", err_cyc_q.size() - be);
        end else begin
            n_run++;
            if (err_cyc_q[be] - s != 2 + TIMEOUT + 1) begin
                n_fail++;
                $display("FAIL timeout_cycle: got %0d expected %0d", err_cyc_q[be] - s,
                         2 + TIMEOUT + 1);
            end
        end
        n_run++;
        if (error !== 1'b1 || busy !== 1'b0 || done_cyc_q.size() != bd || wr_addr_q.size() != bw) begin
            n_fail++;
            $display("FAIL timeout_state: got error=%b busy=%b dones=%0d writes=%0d expected 1/0/0/0",
                     error, busy, done_cyc_q.size() - bd, wr_addr_q.size() - bw);
        end
        stall = 1'b0;
        pulse_start(s);
        n_run++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_clear: got error=%b busy=%b expected 0/1", error, busy);
        end
        wait_until(s + OC * (3 + TCORE) + 8);
        n_run++;
        if (wr_addr_q.size() - bw != OC || done_cyc_q.size() - bd != 1) begin
            n_fail++;
            $display("FAIL timeout_recover: got writes=%0d dones=%0d expected %0d/1",
                     wr_addr_q.size() - bw, done_cyc_q.size() - bd, OC);
        end
    endtask

    task automatic test_valid_at_timeout();
        int s, bw;
        core_lat = TIMEOUT;
        bw = wr_addr_q.size();
        pulse_start(s);
        wait_until(s + OC * (3 + TIMEOUT) + 8);
        n_run++;
        if (wr_addr_q.size() - bw != OC || error !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_at_timeout: got writes=%0d error=%b expected %0d/0",
                     wr_addr_q.size() - bw, error, OC);
        end else begin
            n_run++;
            if (wr_cyc_q[bw] - s != 3 + TIMEOUT) begin
                n_fail++;
                $display("FAIL valid_at_timeout_cycle: got %0d expected %0d", wr_cyc_q[bw] - s,
                         3 + TIMEOUT);
            end
        end
        core_lat = TCORE;
    endtask

    task automatic test_spurious_valid();
        int s, bw;
        bw = wr_addr_q.size();
        @(posedge clk);
        #1 spurious = 1'b1;
        @(posedge clk);
        #1 spurious = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_run++;
        if (busy !== 1'b0 || wr_addr_q.size() != bw) begin
            n_fail++;
            $display("FAIL spurious_idle: got busy=%b writes=%0d expected 0/0",
                     busy, wr_addr_q.size() - bw);
        end
        // Pulse during FETCH; the layer must proceed with normal timing.
        pulse_start(s);
        spurious = 1'b1;
        @(posedge clk);
        #1 spurious = 1'b0;
        wait_until(s + OC * (3 + TCORE) + 8);
        n_run++;
        if (wr_addr_q.size() - bw != OC || wr_cyc_q[bw] - s != 3 + TCORE) begin
            n_fail++;
            $display("FAIL spurious_fetch: got writes=%0d expected %0d with first at +%0d",
                     wr_addr_q.size() - bw, OC, 3 + TCORE);
        end
    endtask

    task automatic test_reset_mid();
        int s, bw, br;
        pulse_start(s);
        wait_until(s + 20);
        #2 rst_n = 1'b0;
        #1;
        n_run++;
        if ({busy, done, error, wt_rd_en, core_en, fmap_we} !== 6'b0 ||
            {wt_addr, fmap_addr, core_weights, fmap_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got flags=%b data=%h expected all 0",
                     {busy, done, error, wt_rd_en, core_en, fmap_we},
                     {wt_addr, fmap_addr, core_weights, fmap_data});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        bw = wr_addr_q.size(); br = rd_addr_q.size();
        repeat (3 + TCORE + 5) @(posedge clk);
        #1;
        n_run++;
        if (busy !== 1'b0 || wr_addr_q.size() != bw || rd_addr_q.size() != br) begin
            n_fail++;
            $display("FAIL reset_mid_idle: got busy=%b writes=%0d reads=%0d expected 0/0/0",
                     busy, wr_addr_q.size() - bw, rd_addr_q.size() - br);
        end
    endtask

    initial begin
        test_reset();
        test_full_layer(1'b1, 1'b0);
        test_full_layer(1'b0, 1'b1);
        for (int k = 0; k < 3; k++) test_full_layer(1'b0, 1'b0);
        test_abort();
        test_timeout();
        test_valid_at_timeout();
        test_spurious_valid();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish within 50000 cycles");
        $fatal(1);
    end

endmodule
